// File: rtl/stream_image_loader.sv
// Streams a framed image (M, N header then M*N*CHANNELS words) into the pixel buffer
// through a registered write port; flags completion or oversize rejection.
module stream_image_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIM_WIDTH  = 16,
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned DEPTH      = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIM_WIDTH-1:0]  M,
    output logic [DIM_WIDTH-1:0]  N,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [31:0]           dataCount,
    output logic                  loadF,
    output logic                  err
);

    localparam int unsigned CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned HDR_BEATS = (DIM_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int unsigned HCNT_W    = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam int unsigned PROD_W    = 2 * DIM_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_M, S_HDR_N, S_CHECK, S_PIXELS, S_DONE, S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic                    in_ready_q;
    logic [DIM_WIDTH-1:0]    m_q, n_q;
    logic [HCNT_W-1:0]       hcnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CHAN_W-1:0]       chan_q;
    logic [31:0]             cnt_q, last_q;
    logic                    wr_en_q, loadf_q, err_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [CHAN_W-1:0]       wr_chan_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    logic                    accept_c, hdr_last_c, pix_last_c, oversize_c, restart_c;
    logic [PROD_W-1:0]       total_c;

    assign accept_c   = in_valid & in_ready_q;
    assign hdr_last_c = (hcnt_q == HCNT_W'(HDR_BEATS - 1));
    assign pix_last_c = (cnt_q == last_q);
    assign total_c    = PROD_W'(m_q) * PROD_W'(n_q);
    assign oversize_c = 64'(total_c) > 64'(DEPTH);
    assign restart_c  = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_HDR_M;
            S_HDR_M:  if (accept_c && hdr_last_c) state_d = S_HDR_N;
            S_HDR_N:  if (accept_c && hdr_last_c) state_d = S_CHECK;
            S_CHECK: begin
                if (oversize_c)                  state_d = S_ERR;
                else if (total_c == PROD_W'(0))  state_d = S_DONE;
                else                             state_d = S_PIXELS;
            end
            S_PIXELS: if (accept_c && pix_last_c) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            m_q        <= '0;
            n_q        <= '0;
            hcnt_q     <= '0;
            addr_q     <= '0;
            chan_q     <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_chan_q  <= '0;
            wr_data_q  <= '0;
            loadf_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == S_HDR_M) | (state_d == S_HDR_N) | (state_d == S_PIXELS);
            wr_en_q    <= 1'b0;
            if (restart_c) begin
                m_q     <= '0;
                n_q     <= '0;
                hcnt_q  <= '0;
                addr_q  <= '0;
                chan_q  <= '0;
                cnt_q   <= '0;
                loadf_q <= 1'b0;
                err_q   <= 1'b0;
            end
            case (state_q)
                S_HDR_M: if (accept_c) begin
                    m_q    <= DIM_WIDTH'({m_q, in_data});
                    hcnt_q <= hdr_last_c ? '0 : hcnt_q + HCNT_W'(1);
                end
                S_HDR_N: if (accept_c) begin
                    n_q    <= DIM_WIDTH'({n_q, in_data});
                    hcnt_q <= hdr_last_c ? '0 : hcnt_q + HCNT_W'(1);
                end
                S_CHECK: begin
                    // Index of the final word; only meaningful when the frame fits.
                    last_q  <= 32'(total_c) * 32'(CHANNELS) - 32'd1;
                    err_q   <= oversize_c;
                    loadf_q <= ~oversize_c & (total_c == PROD_W'(0));
                end
                S_PIXELS: if (accept_c) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addr_q;
                    wr_chan_q <= chan_q;
                    wr_data_q <= in_data;
                    cnt_q     <= cnt_q + 32'd1;
                    if (chan_q == CHAN_W'(CHANNELS - 1)) begin
                        chan_q <= '0;
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                    end else begin
                        chan_q <= chan_q + CHAN_W'(1);
                    end
                    if (pix_last_c) loadf_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign M         = m_q;
    assign N         = n_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_chan   = wr_chan_q;
    assign wr_data   = wr_data_q;
    assign dataCount = cnt_q;
    assign loadF     = loadf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_stream_image_loader.sv
// Random-stimulus bench for stream_image_loader: one CHANNELS=1 and one CHANNELS=3
// instance, each compared cycle by cycle against a frame-level reference model.
module tb_stream_image_loader;

    localparam int unsigned DEP = 256;

    typedef enum {PH_HDR, PH_CHECK, PH_PIX, PH_DONE, PH_ERR} ph_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_c, vld;
    logic [7:0] din;
    int         sel;
    int         checks = 0;
    int         errors = 0;

    logic        start0, start1, vld0, vld1;
    logic        rdy0, rdy1, we0, we1, lf0, lf1, er0, er1;
    logic [15:0] m0, m1, n0, n1, wa0, wa1;
    logic [0:0]  wc0;
    logic [1:0]  wc1;
    logic [7:0]  wd0, wd1;
    logic [31:0] dc0, dc1;

    assign start0 = start_c && (sel == 0);
    assign start1 = start_c && (sel == 1);
    assign vld0   = vld && (sel == 0);
    assign vld1   = vld && (sel == 1);

    stream_image_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DIM_WIDTH(16), .CHANNELS(1), .DEPTH(DEP)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .in_data(din), .in_valid(vld0), .in_ready(rdy0),
        .M(m0), .N(n0), .wr_en(we0), .wr_addr(wa0), .wr_chan(wc0), .wr_data(wd0),
        .dataCount(dc0), .loadF(lf0), .err(er0));

    stream_image_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DIM_WIDTH(16), .CHANNELS(3), .DEPTH(DEP)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_data(din), .in_valid(vld1), .in_ready(rdy1),
        .M(m1), .N(n1), .wr_en(we1), .wr_addr(wa1), .wr_chan(wc1), .wr_data(wd1),
        .dataCount(dc1), .loadF(lf1), .err(er1));

    logic        o_rdy, o_we, o_lf, o_er;
    logic [15:0] o_m, o_n, o_wa;
    logic [1:0]  o_wc;
    logic [7:0]  o_wd;
    logic [31:0] o_dc;

    always_comb begin
        if (sel == 1) begin
            o_rdy = rdy1; o_we = we1; o_lf = lf1; o_er = er1; o_m = m1; o_n = n1;
            o_wa = wa1; o_wc = wc1; o_wd = wd1; o_dc = dc1;
        end else begin
            o_rdy = rdy0; o_we = we0; o_lf = lf0; o_er = er0; o_m = m0; o_n = n0;
            o_wa = wa0; o_wc = {1'b0, wc0}; o_wd = wd0; o_dc = dc0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (dut%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", 64'(o_rdy), 64'(0));
        chk("rst_M",        64'(o_m),   64'(0));
        chk("rst_N",        64'(o_n),   64'(0));
        chk("rst_wr_en",    64'(o_we),  64'(0));
        chk("rst_wr_addr",  64'(o_wa),  64'(0));
        chk("rst_wr_chan",  64'(o_wc),  64'(0));
        chk("rst_wr_data",  64'(o_wd),  64'(0));
        chk("rst_count",    64'(o_dc),  64'(0));
        chk("rst_loadF",    64'(o_lf),  64'(0));
        chk("rst_err",      64'(o_er),  64'(0));
    endtask

    // Streams one frame to instance d and checks every cycle against the model.
    // abort_at >= 0 pulls reset once that many writes have been seen.
    task automatic run_frame(input int d, input int m, input int n, input bit gaps,
                             input int abort_at, input bit fixed_pix);
        logic [7:0] beats[$];
        int  ch, total, words, idx, hdr_got, acc_pix, wr_seen, settle;
        int  pend_addr, pend_chan, pend_cnt;
        logic [7:0] pend_data;
        bit  oversize, pend, tog, want, acc, exp_rdy, done_ok;
        ph_t ph, nph;

        ch       = (d == 1) ? 3 : 1;
        total    = m * n;
        oversize = total > int'(DEP);
        words    = oversize ? 0 : total * ch;
        beats    = {8'(m >> 8), 8'(m), 8'(n >> 8), 8'(n)};
        for (int k = 0; k < words; k++)
            beats.push_back(fixed_pix ? 8'(8'hA0 + k) : 8'($urandom));
        if (oversize)
            for (int k = 0; k < 4; k++) beats.push_back(8'($urandom));

        sel = d;
        @(negedge clk); start_c = 1'b1; vld = 1'b0;
        @(negedge clk); start_c = 1'b0;
        chk("start_M_clr",   64'(o_m),  64'(0));
        chk("start_N_clr",   64'(o_n),  64'(0));

        ph = PH_HDR; idx = 0; hdr_got = 0; acc_pix = 0; wr_seen = 0; settle = 0;
        pend = 1'b0; tog = 1'b0; done_ok = 1'b0;
        pend_addr = 0; pend_chan = 0; pend_cnt = 0; pend_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_rdy = (ph == PH_HDR) || (ph == PH_PIX);
            chk("in_ready", 64'(o_rdy), 64'(exp_rdy));
            if (pend) begin
                wr_seen++;
                chk("wr_en",   64'(o_we), 64'(1));
                chk("wr_addr", 64'(o_wa), 64'(pend_addr));
                chk("wr_chan", 64'(o_wc), 64'(pend_chan));
                chk("wr_data", 64'(o_wd), 64'(pend_data));
                chk("wr_count", 64'(o_dc), 64'(pend_cnt));
            end else begin
                chk("wr_en_idle", 64'(o_we), 64'(0));
            end
            chk("dataCount", 64'(o_dc), 64'(wr_seen));
            chk("loadF", 64'(o_lf), 64'(ph == PH_DONE));
            chk("err",   64'(o_er), 64'(ph == PH_ERR));
            if (ph != PH_HDR) begin
                chk("M", 64'(o_m), 64'(m));
                chk("N", 64'(o_n), 64'(n));
            end

            if (abort_at >= 0 && wr_seen == abort_at) begin
                vld = 1'b1; din = beats[idx]; rst = 1'b0;
                @(negedge clk); rst = 1'b1;
                chk_reset();
                for (int k = 0; k < 6; k++) begin
                    vld = 1'b1; din = beats[idx];
                    @(negedge clk);
                    chk("abort_wr_en", 64'(o_we),  64'(0));
                    chk("abort_ready", 64'(o_rdy), 64'(0));
                    chk("abort_count", 64'(o_dc),  64'(0));
                end
                vld = 1'b0;
                return;
            end

            if (ph == PH_DONE || ph == PH_ERR) begin
                settle++;
                if (settle > 3) begin done_ok = 1'b1; break; end
            end

            want = (idx < beats.size()) && !(gaps && tog);
            tog  = !tog;
            vld  = want;
            din  = want ? beats[idx] : 8'($urandom);
            acc  = want && exp_rdy;
            pend = 1'b0;
            nph  = ph;
            case (ph)
                PH_HDR: if (acc) begin
                    idx++; hdr_got++;
                    if (hdr_got == 4) nph = PH_CHECK;
                end
                PH_CHECK: nph = oversize ? PH_ERR : ((total == 0) ? PH_DONE : PH_PIX);
                PH_PIX: if (acc) begin
                    pend      = 1'b1;
                    pend_addr = acc_pix / ch;
                    pend_chan = acc_pix % ch;
                    pend_data = beats[idx];
                    idx++; acc_pix++;
                    pend_cnt  = acc_pix;
                    if (acc_pix == words) nph = PH_DONE;
                end
                default: ;
            endcase
            ph = nph;
            @(negedge clk);
        end
        vld = 1'b0;
        if (!done_ok) chk("frame_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        rst = 1'b0; start_c = 1'b0; vld = 1'b0; din = '0; sel = 0;
        repeat (3) @(negedge clk);
        sel = 0; #1 chk_reset();
        sel = 1; #1 chk_reset();
        rst = 1'b1;
        @(negedge clk);

        run_frame(0, 4, 3, 1'b0, -1, 1'b1);   // A0..AB, continuous valid
        run_frame(0, 4, 3, 1'b1, -1, 1'b0);   // valid toggling
        run_frame(1, 2, 2, 1'b0, -1, 1'b0);   // three channels
        run_frame(0, 16, 17, 1'b0, -1, 1'b0); // oversize reject
        run_frame(0, 2, 2, 1'b0, -1, 1'b0);   // recovery after reject
        run_frame(0, 0, 5, 1'b0, -1, 1'b0);   // zero-size frame
        run_frame(0, 4, 3, 1'b0, 5, 1'b0);    // reset mid-frame
        run_frame(0, 4, 3, 1'b0, -1, 1'b1);   // restart from address 0
        run_frame(1, 16, 17, 1'b1, -1, 1'b0);
        for (int r = 0; r < 8; r++)
            run_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, 9)),
                      int'($urandom_range(1, 9)), 1'($urandom), -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
